bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the 11011 sequence-detector chain. It accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock onto a serial line that the detector samples every cycle. A one-word pending buffer lets consecutive words stream with no idle gap. When no word is being shifted, the line is held at a fixed idle level.

## Interface
- WIDTH, 8: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_BIT, 0: level driven on ser_out while not shifting.

- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit, wired to the detector input.
- ser_valid  output  1  ser_out carries a data bit, not the idle level.
- word_done  output  1  one-cycle pulse while the last bit of a word is driven.

## Operation
- Acceptance: a word is accepted on any rising edge where din_valid=1 and din_ready=1.
- Pending buffer:
  - pbuf holds one WIDTH-bit word; pvalid flags it as full.
  - din_ready = !pvalid, so the block never accepts while the buffer is full.
  - On acceptance: pbuf <= din, pvalid <= 1.
- State machine, with states IDLE and SHIFT:
  - IDLE: if pvalid=1, load sreg <= pbuf, cnt <= 0, clear pvalid, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT, cnt < WIDTH-1: shift sreg one place toward the output end, cnt <= cnt+1.
  - SHIFT, cnt == WIDTH-1 (last bit):
    - If pvalid=1: reload sreg <= pbuf, cnt <= 0, clear pvalid, stay in SHIFT.
    - Otherwise: go to IDLE.
- Outputs (combinational from registers):
  - ser_out = sreg[WIDTH-1] if MSB_FIRST=1, sreg[0] if MSB_FIRST=0. It is forced to IDLE_BIT in IDLE.
  - ser_valid = (state == SHIFT).
  - word_done = (state == SHIFT) && (cnt == WIDTH-1).
- cnt width: $clog2(WIDTH). No wrap beyond WIDTH-1 is permitted.
- Invalid state encoding: recover to IDLE, clear pvalid.
- Reset, including mid-word:
  - state = IDLE, cnt = 0, sreg = 0, pvalid = 0.
  - Any partially shifted word and any pending word are discarded.
  - Output values during and after reset: ser_out = IDLE_BIT, ser_valid = 0, word_done = 0, din_ready = 1.
- din_valid asserted during reset is ignored; nothing is accepted while rst=1.

## Timing
- Accept edge k → pvalid set after k → load on edge k+1 → first data bit on ser_out in the cycle after edge k+1. This is 2 cycles of latency, counted from the acceptance edge.
- A word occupies exactly WIDTH consecutive ser_valid cycles.
- Streaming:
  - The reload on the last bit clears pvalid, so din_ready rises the next cycle.
  - The next word can then be accepted and is waiting well before the next last bit, because WIDTH >= 2.
  - A source that presents a word whenever din_ready is high therefore gets a gapless bit stream.
- If the buffer is empty on the last bit, ser_valid drops for at least one cycle. The next word then follows the 2-cycle latency rule.
- din_ready depends only on registered state, never combinationally on din_valid.

## Structure
- The shared FSM package holds the state localparams (IDLE, SHIFT) alongside the detector's state constants, plus a common IDLE_BIT default.
- Single flat module; no sub-module is warranted. The pending buffer is two registers and is not split out.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, din=8'b11011000, accepted at edge 0 → ser_out=1,1,0,1,1,0,0,0 in cycles 2–9. ser_valid high for exactly those 8 cycles; word_done high in cycle 9 only.
- Back-to-back words 8'hDB then 8'h6C, din_valid held high → 16 contiguous ser_valid cycles carrying 11011011 01101100. When fed to the detector, this yields the expected overlapping 11011 hits.
- Backpressure → din_ready low whenever pvalid=1. A din_valid held high across that window is accepted exactly once per word, with no duplication and no loss.
- MSB_FIRST=0, din=8'h1B → ser_out=1,1,0,1,1,0,0,0 (LSB first).
- rst asserted after the 3rd bit of 8'hFF while a pending word 8'hAA is buffered → ser_out=IDLE_BIT and ser_valid=0 from the next cycle. 8'hAA is never emitted; din_ready=1 after reset.
- Idle for 20 cycles with IDLE_BIT=0 → ser_out=0 and ser_valid=0 throughout; word_done never pulses.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared FSM constants for the 11011 detector chain: serializer states,
// detector states and the common idle line level.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } ser_state_e;

  localparam logic [2:0] DET_S0 = 3'd0;
  localparam logic [2:0] DET_S1 = 3'd1;
  localparam logic [2:0] DET_S2 = 3'd2;
  localparam logic [2:0] DET_S3 = 3'd3;
  localparam logic [2:0] DET_S4 = 3'd4;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between a parallel source and the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, word_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, word_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word pending buffer feeding a shift
// register so back-to-back words leave as a gapless bit stream.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  bit_serializer_if.slave  s_if
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       r_state;
  ser_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_pbuf;
  logic             r_pvalid;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_load;
  logic w_shift;
  logic w_drop_pend;
  logic w_last;
  logic w_head;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] s);
    if (MSB_FIRST != 0) return {s[WIDTH-2:0], 1'b0};
    else                return {1'b0, s[WIDTH-1:1]};
  endfunction

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = s_if.din_valid && !r_pvalid && !rst;
  assign w_head   = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_drop_pend = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pvalid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_last)       w_shift     = 1'b1;
        else if (r_pvalid) w_load      = 1'b1;
        else               w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_drop_pend = 1'b1;
      end
    endcase
  end

  always_comb begin
    s_if.ser_out   = IDLE_BIT;
    s_if.ser_valid = 1'b0;
    s_if.word_done = 1'b0;
    s_if.din_ready = !r_pvalid;
    if (r_state == ST_SHIFT) begin
      s_if.ser_out   = w_head;
      s_if.ser_valid = 1'b1;
      s_if.word_done = w_last;
    end
  end

  // Accept and load never coincide: accept needs an empty buffer, load a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_pvalid <= 1'b0;
    end else begin
      if (w_load) begin
        r_sreg <= r_pbuf;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_sreg <= shift_one(r_sreg);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_accept)                r_pvalid <= 1'b1;
      else if (w_load || w_drop_pend) r_pvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pbuf <= s_if.din;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus;
// a word-schedule model predicts every output each cycle.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) if_m ();
  bit_serializer_if #(.WIDTH(8)) if_l ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
    .clk (clk), .rst (rst), .s_if (if_m)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .s_if (if_l)
  );

  typedef struct {
    logic [7:0] w;
    int         acc;
    int         start;
  } ent_t;

  ent_t  q[$];
  int    t        = 0;
  int    last_end = -100;
  logic  exp_rdy  = 1'b1;
  logic  accepted;
  int    checks   = 0;
  int    errors   = 0;
  logic [15:0] cap_m, cap_l;
  int    vcnt_m, vcnt_l, wd_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, t);
    end
  endtask

  // A word accepted at edge k starts at max(k+1, end of previous word + 1)
  // and the buffer is busy from its accept edge until its start.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    logic esv, ebm, ebl, ewd, erdy;
    int   idx;
    rst = r;
    if_m.din_valid = v; if_l.din_valid = v;
    if_m.din = d;       if_l.din = d;
    @(posedge clk);
    t++;
    accepted = 1'b0;
    if (r) begin
      q.delete();
      last_end = -100;
    end else if (v && exp_rdy) begin
      int s;
      s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
      q.push_back('{w: d, acc: t, start: s});
      last_end = s + 7;
      accepted = 1'b1;
    end
    #1;
    esv = 1'b0; ebm = 1'b0; ebl = 1'b0; ewd = 1'b0; erdy = 1'b1;
    foreach (q[i]) begin
      if (t >= q[i].start && t <= q[i].start + 7) begin
        idx = t - q[i].start;
        esv = 1'b1;
        ebm = q[i].w[7 - idx];
        ebl = q[i].w[idx];
        ewd = (idx == 7);
      end
      if (q[i].acc <= t && t < q[i].start) erdy = 1'b0;
    end
    chk("msb.ser_valid", 16'(if_m.ser_valid), 16'(esv));
    chk("msb.ser_out",   16'(if_m.ser_out),   16'(ebm));
    chk("msb.word_done", 16'(if_m.word_done), 16'(ewd));
    chk("msb.din_ready", 16'(if_m.din_ready), 16'(erdy));
    chk("lsb.ser_valid", 16'(if_l.ser_valid), 16'(esv));
    chk("lsb.ser_out",   16'(if_l.ser_out),   16'(ebl));
    chk("lsb.word_done", 16'(if_l.word_done), 16'(ewd));
    chk("lsb.din_ready", 16'(if_l.din_ready), 16'(erdy));
    exp_rdy = erdy;
    if (if_m.ser_valid === 1'b1) begin cap_m = {cap_m[14:0], if_m.ser_out}; vcnt_m++; end
    if (if_l.ser_valid === 1'b1) begin cap_l = {cap_l[14:0], if_l.ser_out}; vcnt_l++; end
    if (if_m.word_done === 1'b1) wd_m++;
    while (q.size() > 0 && q[0].start + 7 <= t) void'(q.pop_front());
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    do begin
      tick(1'b0, 1'b1, d);
      n++;
    end while (!accepted && n < 50);
    chk("send.accepted", 16'(accepted), 16'd1);
  endtask

  task automatic clr_cap();
    cap_m = '0; cap_l = '0; vcnt_m = 0; vcnt_l = 0; wd_m = 0;
  endtask

  initial begin
    rst = 1'b1;
    if_m.din_valid = 1'b0; if_l.din_valid = 1'b0;
    if_m.din = '0;         if_l.din = '0;
    clr_cap();

    // Reset with din_valid asserted: nothing may be accepted.
    repeat (3) tick(1'b1, 1'b1, 8'h5A);

    // Idle line.
    repeat (20) tick(1'b0, 1'b0, 8'h00);
    chk("idle.valid_cycles", 16'(vcnt_m), 16'd0);
    chk("idle.word_done",    16'(wd_m),   16'd0);

    // Single word, MSB first.
    clr_cap();
    send(8'b1101_1000);
    repeat (12) tick(1'b0, 1'b0, 8'h00);
    chk("single.msb_bits",   cap_m, 16'h00D8);
    chk("single.msb_count",  16'(vcnt_m), 16'd8);
    chk("single.word_done",  16'(wd_m), 16'd1);

    // LSB-first instance on 8'h1B emits 1,1,0,1,1,0,0,0.
    clr_cap();
    send(8'h1B);
    repeat (12) tick(1'b0, 1'b0, 8'h00);
    chk("single.lsb_bits",   cap_l, 16'h00D8);
    chk("single.lsb_count",  16'(vcnt_l), 16'd8);

    // Back-to-back with din_valid held: 16 contiguous bits.
    clr_cap();
    send(8'hDB);
    send(8'h6C);
    repeat (20) tick(1'b0, 1'b0, 8'h00);
    chk("b2b.msb_bits",   cap_m, 16'hDB6C);
    chk("b2b.msb_count",  16'(vcnt_m), 16'd16);
    chk("b2b.word_done",  16'(wd_m), 16'd2);

    // Random valid/data pattern.
    for (int i = 0; i < 400; i++)
      tick(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom));
    repeat (20) tick(1'b0, 1'b0, 8'h00);

    // Reset after the third bit of 8'hFF while 8'hAA waits in the buffer.
    clr_cap();
    send(8'hFF);
    send(8'hAA);
    tick(1'b0, 1'b0, 8'h00);
    chk("rst.bits_before", 16'(vcnt_m), 16'd3);
    tick(1'b1, 1'b1, 8'h55);
    tick(1'b1, 1'b1, 8'h55);
    repeat (15) tick(1'b0, 1'b0, 8'h00);
    chk("rst.no_more_bits", 16'(vcnt_m), 16'd3);
    chk("rst.captured",     cap_m, 16'h0007);
    chk("rst.din_ready",    16'(if_m.din_ready), 16'd1);

    // Stream resumes cleanly after reset.
    for (int i = 0; i < 150; i++)
      tick(1'b0, ($urandom_range(0, 1) != 0), 8'($urandom));
    repeat (20) tick(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
